// File: rtl/top_1.sv
// Brute-force ray/triangle-plane intersection engine: nearest Q16.16 hit per ray.
// Define RTP_HIT_WRITEBACK_EN to store each ray's final best_t back into Ray_hitT.

module rtp_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  // NOTE: memory contents are never reset; only the read register is clocked.
  reg [31:0] mem [0:DEPTH-1];

  always @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clock) rdata <= mem[addr];
endmodule

module top_1 #(
  parameter int NUM_RAYS = 16,
  parameter int NUM_TRIS = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] io_hitT,
  output logic [31:0] io_ray_id_triangle,
  output logic        io_rtp_finish,
  output logic [63:0] io_counter_fdiv
);
  localparam int RAW       = (NUM_RAYS > 1) ? $clog2(NUM_RAYS) : 1;
  localparam int TAW       = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1;
  localparam int DIV_STEPS = 48;

  typedef enum logic [3:0] {
    IDLE, RAY_RD, RAY_LD, TRI_RD, DOT, DIV, CMP, RAY_DONE, FINISH
  } state_t;

  state_t state, state_nxt;

  logic [RAW-1:0]     ray_idx;
  logic [TAW-1:0]     tri_idx;
  logic [31:0]        ox, oy, oz, dx, dy, dz;
  logic signed [31:0] best_t;
  logic [31:0]        best_id;
  logic               den_nz;

  logic [31:0] q_ox, q_oy, q_oz, q_dx, q_dy, q_dz, q_hit;
  logic [31:0] q_tx, q_ty, q_tz, q_tw;
  logic        ray_we;

  rtp_ram #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_origx (.clock(clock), .addr(ray_idx), .we(1'b0), .wdata('0), .rdata(q_ox));
  rtp_ram #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_origy (.clock(clock), .addr(ray_idx), .we(1'b0), .wdata('0), .rdata(q_oy));
  rtp_ram #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_origz (.clock(clock), .addr(ray_idx), .we(1'b0), .wdata('0), .rdata(q_oz));
  rtp_ram #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_dirx  (.clock(clock), .addr(ray_idx), .we(1'b0), .wdata('0), .rdata(q_dx));
  rtp_ram #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_diry  (.clock(clock), .addr(ray_idx), .we(1'b0), .wdata('0), .rdata(q_dy));
  rtp_ram #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_dirz  (.clock(clock), .addr(ray_idx), .we(1'b0), .wdata('0), .rdata(q_dz));
  rtp_ram #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_hitT  (.clock(clock), .addr(ray_idx), .we(ray_we), .wdata(best_t), .rdata(q_hit));

  rtp_ram #(.DEPTH(NUM_TRIS), .AW(TAW)) TRI_RAM_x (.clock(clock), .addr(tri_idx), .we(1'b0), .wdata('0), .rdata(q_tx));
  rtp_ram #(.DEPTH(NUM_TRIS), .AW(TAW)) TRI_RAM_y (.clock(clock), .addr(tri_idx), .we(1'b0), .wdata('0), .rdata(q_ty));
  rtp_ram #(.DEPTH(NUM_TRIS), .AW(TAW)) TRI_RAM_z (.clock(clock), .addr(tri_idx), .we(1'b0), .wdata('0), .rdata(q_tz));
  rtp_ram #(.DEPTH(NUM_TRIS), .AW(TAW)) TRI_RAM_w (.clock(clock), .addr(tri_idx), .we(1'b0), .wdata('0), .rdata(q_tw));

`ifdef RTP_HIT_WRITEBACK_EN
  assign ray_we = (state == RAY_DONE);
`else
  assign ray_we = 1'b0;
`endif

  // Q16.16 multiply: full signed product, >>> 16, low 32 bits kept.
  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    return p[47:16];
  endfunction

  logic [31:0] num_c, den_c, den_mag;
  logic [47:0] dvd_c, num_mag;

  assign num_c   = q_tw - (qmul(ox, q_tx) + qmul(oy, q_ty) + qmul(oz, q_tz));
  assign den_c   = qmul(dx, q_tx) + qmul(dy, q_ty) + qmul(dz, q_tz);
  assign dvd_c   = {num_c, 16'h0000};
  assign num_mag = num_c[31] ? (48'd0 - dvd_c) : dvd_c;
  assign den_mag = den_c[31] ? (32'd0 - den_c) : den_c;

  // Restoring divider on magnitudes; the remainder always stays below the divisor.
  logic [31:0]        div_rem, div_dvs;
  logic [47:0]        div_quo;
  logic               div_neg;
  logic [5:0]         div_cnt;
  logic [32:0]        div_shift, div_diff;
  logic signed [31:0] t_c;

  assign div_shift = {div_rem, div_quo[47]};
  assign div_diff  = div_shift - {1'b0, div_dvs};
  assign t_c       = div_neg ? (32'd0 - div_quo[31:0]) : div_quo[31:0];

  logic tri_last, ray_last, hit_c;
  assign tri_last = (tri_idx == TAW'(NUM_TRIS - 1));
  assign ray_last = (ray_idx == RAW'(NUM_RAYS - 1));
  assign hit_c    = den_nz && (t_c > 32'sd0) && (t_c < best_t);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: combinational logic uses blocking '=' with a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = RAY_RD;
      RAY_RD:   state_nxt = RAY_LD;
      RAY_LD:   state_nxt = TRI_RD;
      TRI_RD:   state_nxt = DOT;
      DOT:      state_nxt = (den_c != 32'd0) ? DIV : CMP;
      DIV:      if (div_cnt == 6'(DIV_STEPS - 1)) state_nxt = CMP;
      CMP:      state_nxt = tri_last ? RAY_DONE : TRI_RD;
      RAY_DONE: state_nxt = ray_last ? FINISH : RAY_RD;
      FINISH:   state_nxt = FINISH;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ray_idx            <= '0;
      tri_idx            <= '0;
      {ox, oy, oz}       <= '0;
      {dx, dy, dz}       <= '0;
      best_t             <= '0;
      best_id            <= '1;
      den_nz             <= 1'b0;
      div_rem            <= '0;
      div_dvs            <= '0;
      div_quo            <= '0;
      div_neg            <= 1'b0;
      div_cnt            <= '0;
      io_hitT            <= '0;
      io_ray_id_triangle <= '1;
      io_rtp_finish      <= 1'b0;
      io_counter_fdiv    <= '0;
    end else begin
      case (state)
        RAY_LD: begin
          ox      <= q_ox;
          oy      <= q_oy;
          oz      <= q_oz;
          dx      <= q_dx;
          dy      <= q_dy;
          dz      <= q_dz;
          best_t  <= q_hit;
          best_id <= '1;
        end
        DOT: begin
          den_nz <= (den_c != 32'd0);
          if (den_c != 32'd0) begin
            div_rem         <= '0;
            div_quo         <= num_mag;
            div_dvs         <= den_mag;
            div_neg         <= num_c[31] ^ den_c[31];
            div_cnt         <= '0;
            io_counter_fdiv <= io_counter_fdiv + 64'd1;
          end
        end
        DIV: begin
          div_cnt <= div_cnt + 6'd1;
          if (!div_diff[32]) begin
            div_rem <= div_diff[31:0];
            div_quo <= {div_quo[46:0], 1'b1};
          end else begin
            div_rem <= div_shift[31:0];
            div_quo <= {div_quo[46:0], 1'b0};
          end
        end
        CMP: begin
          if (hit_c) begin
            best_t  <= t_c;
            best_id <= 32'(tri_idx);
          end
          tri_idx <= tri_last ? '0 : tri_idx + TAW'(1);
        end
        RAY_DONE: begin
          io_hitT            <= best_t;
          io_ray_id_triangle <= best_id;
          if (ray_last) io_rtp_finish <= 1'b1;
          else          ray_idx       <= ray_idx + RAW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_top_1.sv
// Directed bench for top_1: single-ray/single-triangle cases on dut1, two rays by two
// triangles (ordering, clipping, ties, writeback) on dut2, plus a mid-division reset.

module tb_top_1;
  logic clock = 1'b0;
  logic reset1 = 1'b1;
  logic reset2 = 1'b1;

  logic [31:0] hit1, id1, hit2, id2;
  logic        fin1, fin2;
  logic [63:0] cnt1, cnt2;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] TMAX = 32'h7FFF_FFFF;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  always #5 clock = ~clock;

  top_1 #(.NUM_RAYS(1), .NUM_TRIS(1)) dut1 (
    .clock(clock), .reset(reset1), .io_hitT(hit1), .io_ray_id_triangle(id1),
    .io_rtp_finish(fin1), .io_counter_fdiv(cnt1)
  );

  top_1 #(.NUM_RAYS(2), .NUM_TRIS(2)) dut2 (
    .clock(clock), .reset(reset2), .io_hitT(hit2), .io_ray_id_triangle(id2),
    .io_rtp_finish(fin2), .io_counter_fdiv(cnt2)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load1(input logic [31:0] ox, oy, oz, dx, dy, dz, ht,
                       input logic [31:0] tx, ty, tz, tw);
    dut1.Ray_origx.mem[0] <= ox;
    dut1.Ray_origy.mem[0] <= oy;
    dut1.Ray_origz.mem[0] <= oz;
    dut1.Ray_dirx.mem[0]  <= dx;
    dut1.Ray_diry.mem[0]  <= dy;
    dut1.Ray_dirz.mem[0]  <= dz;
    dut1.Ray_hitT.mem[0]  <= ht;
    dut1.TRI_RAM_x.mem[0] <= tx;
    dut1.TRI_RAM_y.mem[0] <= ty;
    dut1.TRI_RAM_z.mem[0] <= tz;
    dut1.TRI_RAM_w.mem[0] <= tw;
  endtask

  // Rays along +z from (0,0,oz); every triangle has normal (0,0,1.0).
  task automatic load2_ray(input int r, input logic [31:0] oz, ht);
    dut2.Ray_origx.mem[r] <= 32'h0;
    dut2.Ray_origy.mem[r] <= 32'h0;
    dut2.Ray_origz.mem[r] <= oz;
    dut2.Ray_dirx.mem[r]  <= 32'h0;
    dut2.Ray_diry.mem[r]  <= 32'h0;
    dut2.Ray_dirz.mem[r]  <= ONE;
    dut2.Ray_hitT.mem[r]  <= ht;
  endtask

  task automatic load2_tri(input int i, input logic [31:0] tw);
    dut2.TRI_RAM_x.mem[i] <= 32'h0;
    dut2.TRI_RAM_y.mem[i] <= 32'h0;
    dut2.TRI_RAM_z.mem[i] <= ONE;
    dut2.TRI_RAM_w.mem[i] <= tw;
  endtask

  // Releases reset1 and checks that finish rises exactly on edge fin_edge after release.
  task automatic run1(input string tag, input logic [31:0] exp_t, exp_id,
                      input logic [63:0] exp_cnt, input int fin_edge);
    @(negedge clock);
    reset1 = 1'b1;
    repeat (fin_edge - 1) @(posedge clock);
    #1 check({tag, ".fin_before"}, 64'(fin1), 64'd0);
    @(posedge clock);
    #1;
    check({tag, ".fin"},  64'(fin1), 64'd1);
    check({tag, ".hitT"}, 64'(hit1), 64'(exp_t));
    check({tag, ".id"},   64'(id1),  64'(exp_id));
    check({tag, ".cnt"},  cnt1,      exp_cnt);
  endtask

  logic [31:0] exp_wb0, exp_wb1;

  initial begin
    #2;
    reset1 = 1'b0;
    reset2 = 1'b0;
    #1;
    check("rst.hitT", 64'(hit1), 64'd0);
    check("rst.id",   64'(id1),  64'(NONE));
    check("rst.fin",  64'(fin1), 64'd0);
    check("rst.cnt",  cnt1,      64'd0);
    check("rst2.id",  64'(id2),  64'(NONE));

    // Basic hit at t = 5.0.
    load1(0, 0, 0, 0, 0, ONE, TMAX, 0, 0, ONE, 32'h0005_0000);
    run1("basic", 32'h0005_0000, 32'd0, 64'd1, 55);
`ifdef RTP_HIT_WRITEBACK_EN
    exp_wb0 = 32'h0005_0000;
`else
    exp_wb0 = TMAX;
`endif
    check("basic.mem", 64'(dut1.Ray_hitT.mem[0]), 64'(exp_wb0));

    // Plane behind the origin: t = -2.0 is rejected.
    #1 reset1 = 1'b0;
    load1(0, 0, 0, 0, 0, ONE, TMAX, 0, 0, ONE, 32'hFFFE_0000);
    run1("behind", TMAX, NONE, 64'd1, 55);

    // Ray parallel to the plane: den = 0, no division.
    #1 reset1 = 1'b0;
    load1(0, 0, 0, 0, 0, ONE, TMAX, ONE, 0, 0, 32'h0005_0000);
    run1("parallel", TMAX, NONE, 64'd0, 7);

    // Negative num and den: -3.0 / -1.0 = 3.0.
    #1 reset1 = 1'b0;
    load1(0, 0, 0, 0, 0, 32'hFFFF_0000, TMAX, 0, 0, ONE, 32'hFFFD_0000);
    run1("negneg", 32'h0003_0000, 32'd0, 64'd1, 55);

    // All components: normal (1,1,1), orig (1,1,1), dir (0,0,2), w=8 -> 5.0/2.0 = 2.5.
    #1 reset1 = 1'b0;
    load1(ONE, ONE, ONE, 0, 0, 32'h0002_0000, TMAX, ONE, ONE, ONE, 32'h0008_0000);
    run1("frac", 32'h0002_8000, 32'd0, 64'd1, 55);

    // Reset during the division, then an uninterrupted rerun.
    #1 reset1 = 1'b0;
    load1(0, 0, 0, 0, 0, ONE, TMAX, 0, 0, ONE, 32'h0005_0000);
    @(negedge clock);
    reset1 = 1'b1;
    repeat (20) @(posedge clock);
    #1 check("middiv.cnt_before", cnt1, 64'd1);
    reset1 = 1'b0;
    #1;
    check("middiv.hitT", 64'(hit1), 64'd0);
    check("middiv.id",   64'(id1),  64'(NONE));
    check("middiv.fin",  64'(fin1), 64'd0);
    check("middiv.cnt",  cnt1,      64'd0);
    repeat (2) @(posedge clock);
    run1("rerun", 32'h0005_0000, 32'd0, 64'd1, 55);

    // dut2 A: tris w=5.0, w=3.0; ray0 from 0, ray1 from z=4.0.
    load2_tri(0, 32'h0005_0000);
    load2_tri(1, 32'h0003_0000);
    load2_ray(0, 32'h0, TMAX);
    load2_ray(1, 32'h0004_0000, TMAX);
    @(negedge clock);
    reset2 = 1'b1;
    repeat (105) @(posedge clock);
    #1 check("A.hitT_before", 64'(hit2), 64'd0);
    @(posedge clock);
    #1;
    check("A.ray0_hitT", 64'(hit2), 64'h0003_0000);
    check("A.ray0_id",   64'(id2),  64'd1);
    check("A.ray0_fin",  64'(fin2), 64'd0);
    repeat (104) @(posedge clock);
    #1 check("A.fin_before", 64'(fin2), 64'd0);
    @(posedge clock);
    #1;
    check("A.fin",       64'(fin2), 64'd1);
    check("A.ray1_hitT", 64'(hit2), 64'h0001_0000);
    check("A.ray1_id",   64'(id2),  64'd0);
    check("A.cnt",       cnt2,      64'd4);
`ifdef RTP_HIT_WRITEBACK_EN
    exp_wb0 = 32'h0003_0000;
    exp_wb1 = 32'h0001_0000;
`else
    exp_wb0 = TMAX;
    exp_wb1 = TMAX;
`endif
    check("A.mem0", 64'(dut2.Ray_hitT.mem[0]), 64'(exp_wb0));
    check("A.mem1", 64'(dut2.Ray_hitT.mem[1]), 64'(exp_wb1));

    // dut2 B: tie at w=5.0; ray0 clipped by tmax 4.0, ray1 unclipped.
    #1 reset2 = 1'b0;
    load2_tri(0, 32'h0005_0000);
    load2_tri(1, 32'h0005_0000);
    load2_ray(0, 32'h0, 32'h0004_0000);
    load2_ray(1, 32'h0, TMAX);
    @(negedge clock);
    reset2 = 1'b1;
    repeat (106) @(posedge clock);
    #1;
    check("B.ray0_hitT", 64'(hit2), 64'h0004_0000);
    check("B.ray0_id",   64'(id2),  64'(NONE));
    repeat (105) @(posedge clock);
    #1;
    check("B.fin",       64'(fin2), 64'd1);
    check("B.ray1_hitT", 64'(hit2), 64'h0005_0000);
    check("B.ray1_id",   64'(id2),  64'd0);
    check("B.cnt",       cnt2,      64'd4);
`ifdef RTP_HIT_WRITEBACK_EN
    exp_wb1 = 32'h0005_0000;
`else
    exp_wb1 = TMAX;
`endif
    check("B.mem0", 64'(dut2.Ray_hitT.mem[0]), 64'h0004_0000);
    check("B.mem1", 64'(dut2.Ray_hitT.mem[1]), 64'(exp_wb1));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
